branch_redirect_ctrl: RTL and testbench
=======================================

Name: branch_redirect_ctrl

Overview:
Sequencing controller for the execute-stage branch/jump decision unit. It takes the decision unit's taken flag and target address, then drives the PC redirect to fetch over a valid/ready handshake. It flushes the IF and ID stages, stalls execute while the redirect drains, traps misaligned targets, and keeps branch statistics. It sits between execute, fetch and the hazard unit.

Parameters:
FLUSH_CYCLES, 2, cycles ID flush stays asserted after fetch accepts the redirect (legal range 1-15)
CNT_W, 32, width of statistics counters

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
ex_valid  input  1  execute stage holds a valid instruction this cycle
ex_opcode  input  7  opcode of the execute-stage instruction
bj_taken  input  1  taken/flush flag from the branch/jump decision unit
bj_target  input  32  target PC from the decision unit
ex_kill  input  1  later-stage trap/interrupt; aborts any pending redirect
redirect_ready  input  1  fetch accepts the redirect this cycle
redirect_valid  output  1  redirect request to fetch
redirect_pc  output  32  redirect target, stable while redirect_valid is high
flush_if  output  1  squash the IF/ID register
flush_id  output  1  squash the ID/EX register
ex_stall  output  1  hold the execute stage
misalign_trap  output  1  one-cycle pulse: taken target not word-aligned
ctrl_count  output  CNT_W  number of control-transfer instructions accepted
taken_count  output  CNT_W  number of redirects issued

Behaviour:
- Control instruction means opcode 1100011 (branch), 1101111 (JAL) or 1100111 (JALR). Any other opcode is ignored.
- The FSM has three states: IDLE, REDIRECT and DRAIN. All outputs are registered or decoded from state only, with no combinational path from inputs.
- Reset (synchronous, any state):
  - state goes to IDLE
  - redirect_valid=0, redirect_pc=0, misalign_trap=0
  - both counters are 0
  - flush_if, flush_id and ex_stall are 0
- Reset mid-REDIRECT drops redirect_valid at that edge.
- IDLE, on ex_valid & control opcode (the "accept" condition):
  - ctrl_count increments.
  - If bj_taken and bj_target[1:0]!=0: misalign_trap=1 for the next cycle only, no redirect, stay in IDLE, taken_count unchanged.
  - If bj_taken and aligned: next cycle redirect_valid=1, redirect_pc=bj_target, state goes to REDIRECT, taken_count increments.
  - If not taken: only ctrl_count increments, stay in IDLE.
- REDIRECT:
  - flush_if=1, flush_id=1, ex_stall=1.
  - redirect_valid and redirect_pc are held stable until redirect_ready.
  - ex_valid and bj_* are ignored.
  - On redirect_ready: redirect_valid=0 at the next edge, load the drain counter with FLUSH_CYCLES, go to DRAIN.
- DRAIN:
  - flush_id=1, ex_stall=1, flush_if=0.
  - The counter decrements each cycle; the state leaves for IDLE when it reaches 1, so flush_id stays high for exactly FLUSH_CYCLES cycles.
- Latency: accept cycle N gives redirect_valid at N+1. If redirect_ready is high at N+1, DRAIN covers N+2 through N+1+FLUSH_CYCLES, and IDLE resumes the following cycle.
- ex_kill has the highest priority in every state:
  - next state is IDLE, redirect_valid=0, drain counter cleared.
  - A kill in the same cycle as an accept suppresses the accept: no counter change, no trap.
- Counters wrap modulo 2^CNT_W. There is no saturation.
- redirect_ready while in IDLE or DRAIN is ignored.

Test Plan:
1. BEQ taken: ex_valid=1, ex_opcode=1100011, bj_taken=1, bj_target=0x00000008, redirect_ready held 1 → cycle+1 redirect_valid=1, redirect_pc=0x8, flush_if=flush_id=1. Then 2 cycles of flush_id only, then IDLE; ctrl_count=1, taken_count=1.
2. BNE not taken: opcode 1100011, bj_taken=0, bj_target=0x8 → no redirect, no flush, ctrl_count increments, taken_count unchanged. The same with opcode 0110011 and bj_taken=1 leaves both counters unchanged.
3. Backpressure: JAL taken to 0x00000100 with redirect_ready=0 for 5 cycles → redirect_valid and redirect_pc=0x100 held stable, flush_if/ex_stall high throughout. ready=1 → DRAIN for FLUSH_CYCLES cycles, then IDLE.
4. Misaligned: JALR taken to 0x00000006 → misalign_trap pulses exactly one cycle, redirect_valid stays 0, ctrl_count increments, taken_count does not.
5. Kill: taken branch to 0x20, ex_kill=1 on the second cycle of REDIRECT → redirect_valid=0 and all flush outputs 0 at the next edge, state IDLE. Kill coincident with an accept → no counter change.
6. Reset/wrap: CNT_W=4, 16 accepted not-taken branches → ctrl_count wraps to 0. rst=1 mid-REDIRECT → all outputs 0 after the next rising edge.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: sequences execute-stage branch/jump redirects to fetch with flush, stall, misalign trap and statistics
module branch_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [6:0]       ex_opcode,
  input  logic             bj_taken,
  input  logic [31:0]      bj_target,
  input  logic             ex_kill,
  input  logic             redirect_ready,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush_if,
  output logic             flush_id,
  output logic             ex_stall,
  output logic             misalign_trap,
  output logic [CNT_W-1:0] ctrl_count,
  output logic [CNT_W-1:0] taken_count
);
  typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;
  state_t state, state_nx;
  logic [3:0] drain_cnt, drain_nx;
  logic is_ctrl, accept, misaligned, go;
  assign is_ctrl = ex_opcode == 7'b1100011 || ex_opcode == 7'b1101111 || ex_opcode == 7'b1100111;
  assign accept = state == IDLE && ex_valid && is_ctrl && !ex_kill;
  assign misaligned = bj_target[1:0] != 2'b00;
  assign go = accept && bj_taken && !misaligned;
  always_comb begin
    state_nx = state;
    drain_nx = drain_cnt;
    if (ex_kill) begin
      state_nx = IDLE;
      drain_nx = '0;
    end else if (state == IDLE) begin
      state_nx = go ? REDIRECT : IDLE;
    end else if (state == REDIRECT) begin
      state_nx = redirect_ready ? DRAIN : REDIRECT;
      drain_nx = redirect_ready ? 4'(FLUSH_CYCLES) : drain_cnt;
    end else begin
      state_nx = drain_cnt <= 4'd1 ? IDLE : DRAIN;
      drain_nx = drain_cnt <= 4'd1 ? 4'd0 : drain_cnt - 4'd1;
    end
  end
  // Handshake and flush/stall outputs decode straight from state, so no input reaches them combinationally
  assign redirect_valid = state == REDIRECT;
  assign flush_if = state == REDIRECT;
  assign flush_id = state != IDLE;
  assign ex_stall = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      drain_cnt <= '0;
      redirect_pc <= '0;
      misalign_trap <= 1'b0;
      ctrl_count <= '0;
      taken_count <= '0;
    end else begin
      state <= state_nx;
      drain_cnt <= drain_nx;
      misalign_trap <= accept && bj_taken && misaligned;
      if (accept) ctrl_count <= ctrl_count + CNT_W'(1);
      if (go) begin
        redirect_pc <= bj_target;
        taken_count <= taken_count + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed plus randomized checks against a behavioural redirect model
module tb_branch_redirect_ctrl;
  localparam int FC = 2;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_ALU = 7'b0110011;
  logic clk = 1'b0, rst = 1'b1, ex_valid = 1'b0, bj_taken = 1'b0, ex_kill = 1'b0, redirect_ready = 1'b0;
  logic [6:0] ex_opcode = 7'd0;
  logic [31:0] bj_target = 32'd0;
  logic redirect_valid, flush_if, flush_id, ex_stall, misalign_trap;
  logic [31:0] redirect_pc, ctrl_count, taken_count;
  logic s_valid, s_fif, s_fid, s_stall, s_trap;
  logic [31:0] s_pc;
  logic [3:0] s_cc, s_tc;
  int checks = 0, errors = 0;
  bit m_pend, m_trap;
  int m_drain;
  logic [31:0] m_pc;
  int unsigned m_cc, m_tc;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .bj_taken(bj_taken),
    .bj_target(bj_target), .ex_kill(ex_kill), .redirect_ready(redirect_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush_if(flush_if), .flush_id(flush_id),
    .ex_stall(ex_stall), .misalign_trap(misalign_trap), .ctrl_count(ctrl_count), .taken_count(taken_count));

  branch_redirect_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .bj_taken(bj_taken),
    .bj_target(bj_target), .ex_kill(ex_kill), .redirect_ready(redirect_ready),
    .redirect_valid(s_valid), .redirect_pc(s_pc), .flush_if(s_fif), .flush_id(s_fid),
    .ex_stall(s_stall), .misalign_trap(s_trap), .ctrl_count(s_cc), .taken_count(s_tc));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: a pending redirect flag plus a count of remaining ID-flush cycles
  task automatic model_edge();
    bit is_ctrl;
    is_ctrl = ex_opcode inside {OP_BR, OP_JAL, OP_JALR};
    m_trap = 1'b0;
    if (rst) begin
      m_pend = 1'b0; m_drain = 0; m_pc = '0; m_cc = 0; m_tc = 0;
    end else if (ex_kill) begin
      m_pend = 1'b0; m_drain = 0;
    end else if (m_pend) begin
      if (redirect_ready) begin m_pend = 1'b0; m_drain = FC; end
    end else if (m_drain > 0) begin
      m_drain--;
    end else if (ex_valid && is_ctrl) begin
      m_cc++;
      if (bj_taken && bj_target[1:0] != 2'b00) m_trap = 1'b1;
      else if (bj_taken) begin m_pend = 1'b1; m_pc = bj_target; m_tc++; end
    end
  endtask

  task automatic check_all();
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_pend});
    chk("flush_if", {31'd0, flush_if}, {31'd0, m_pend});
    chk("flush_id", {31'd0, flush_id}, {31'd0, m_pend || m_drain > 0});
    chk("ex_stall", {31'd0, ex_stall}, {31'd0, m_pend || m_drain > 0});
    chk("misalign_trap", {31'd0, misalign_trap}, {31'd0, m_trap});
    chk("ctrl_count", ctrl_count, m_cc);
    chk("taken_count", taken_count, m_tc);
    if (m_pend) chk("redirect_pc", redirect_pc, m_pc);
    chk("ctrl_count_w4", {28'd0, s_cc}, m_cc & 32'hF);
    chk("taken_count_w4", {28'd0, s_tc}, m_tc & 32'hF);
  endtask

  task automatic step(input logic r, input logic v, input logic [6:0] op, input logic tk,
                      input logic [31:0] tg, input logic k, input logic rdy);
    rst = r; ex_valid = v; ex_opcode = op; bj_taken = tk; bj_target = tg; ex_kill = k; redirect_ready = rdy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, OP_ALU, 1'b0, 32'd0, 1'b0, rdy);
  endtask

  initial begin
    logic [6:0] op;
    logic [31:0] tg;
    step(1'b1, 1'b0, OP_ALU, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("reset_pc", redirect_pc, 32'd0);
    step(1'b0, 1'b1, OP_BR, 1'b1, 32'h8, 1'b0, 1'b1);
    chk("beq_pc", redirect_pc, 32'h8);
    idle(4, 1'b1);
    step(1'b0, 1'b1, OP_BR, 1'b0, 32'h8, 1'b0, 1'b0);
    step(1'b0, 1'b1, OP_ALU, 1'b1, 32'h8, 1'b0, 1'b0);
    idle(1, 1'b0);
    step(1'b0, 1'b1, OP_JAL, 1'b1, 32'h100, 1'b0, 1'b0);
    idle(5, 1'b0);
    chk("bp_pc", redirect_pc, 32'h100);
    idle(5, 1'b1);
    step(1'b0, 1'b1, OP_JALR, 1'b1, 32'h6, 1'b0, 1'b1);
    idle(2, 1'b0);
    step(1'b0, 1'b1, OP_BR, 1'b1, 32'h20, 1'b0, 1'b0);
    idle(1, 1'b0);
    step(1'b0, 1'b0, OP_ALU, 1'b0, 32'd0, 1'b1, 1'b0);
    idle(1, 1'b1);
    step(1'b0, 1'b1, OP_BR, 1'b1, 32'h40, 1'b1, 1'b1);
    step(1'b1, 1'b0, OP_ALU, 1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, OP_BR, 1'b0, 32'h4, 1'b0, 1'b0);
    chk("wrap_w4", {28'd0, s_cc}, 32'd0);
    step(1'b0, 1'b1, OP_JAL, 1'b1, 32'h44, 1'b0, 1'b0);
    step(1'b1, 1'b0, OP_ALU, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("rst_mid_pc", redirect_pc, 32'd0);
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 4))
        0: op = OP_BR;
        1: op = OP_JAL;
        2: op = OP_JALR;
        3: op = OP_ALU;
        default: op = 7'($urandom);
      endcase
      tg = $urandom;
      if ($urandom_range(0, 3) != 0) tg[1:0] = 2'b00;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, op, $urandom_range(0, 2) != 0,
           tg, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
